// File: rtl/pe_operand_feeder.sv
// Operand feeder for the convolution PE: buffers one filter row and one ifmap row,
// then issues the 1-D sliding-window MAC schedule one operand pair per cycle.
module pe_operand_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FLTR_MAX   = 5,
    parameter int IFMAP_MAX  = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [$clog2(FLTR_MAX+1)-1:0]  cfg_fltr_len,
    input  logic [$clog2(IFMAP_MAX+1)-1:0] cfg_ifmap_len,
    input  logic                           fltr_valid,
    output logic                           fltr_ready,
    input  logic [DATA_WIDTH-1:0]          fltr_data,
    input  logic                           ifmap_valid,
    output logic                           ifmap_ready,
    input  logic [DATA_WIDTH-1:0]          ifmap_data,
    input  logic                           pe_ready,
    output logic                           pe_valid,
    output logic [DATA_WIDTH-1:0]          pe_ifmap_data,
    output logic [DATA_WIDTH-1:0]          pe_fltr_data,
    output logic                           pe_mult_seln,
    output logic                           pe_acc_seln,
    output logic                           pe_last,
    output logic                           busy,
    output logic                           cfg_err
);
    localparam int KW = $clog2(FLTR_MAX + 1);
    localparam int WW = $clog2(IFMAP_MAX + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD_FLTR  = 3'd1;
    localparam logic [2:0] S_LOAD_IFMAP = 3'd2;
    localparam logic [2:0] S_COMPUTE    = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [KW-1:0]         k_len_q, k_len_d;
    logic [WW-1:0]         w_len_q, w_len_d;
    logic [WW-1:0]         ld_cnt_q, ld_cnt_d;
    logic [WW-1:0]         o_q, o_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  last_ld_q, last_ld_d;
    logic                  drain_q, drain_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  pe_valid_q, pe_valid_d;
    logic [DATA_WIDTH-1:0] pe_ifmap_q, pe_ifmap_d;
    logic [DATA_WIDTH-1:0] pe_fltr_q, pe_fltr_d;
    logic                  pe_mult_q, pe_mult_d;
    logic                  pe_acc_q, pe_acc_d;
    logic                  pe_last_q, pe_last_d;

    // Row buffers are sized to the counter ranges so every index is exactly in range.
    logic [DATA_WIDTH-1:0] tap_mem [0:(1<<KW)-1];
    logic [DATA_WIDTH-1:0] pix_mem [0:(1<<WW)-1];

    logic cfg_bad;
    logic k_is_last;

    assign cfg_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fltr_ready  = (state_q == S_LOAD_FLTR);
    assign ifmap_ready = (state_q == S_LOAD_IFMAP);

    assign cfg_bad = (cfg_fltr_len == '0) || (cfg_ifmap_len == '0) ||
                     (cfg_fltr_len > KW'(FLTR_MAX)) || (cfg_ifmap_len > WW'(IFMAP_MAX)) ||
                     (cfg_ifmap_len < WW'(cfg_fltr_len));
    assign k_is_last = (k_q == k_len_q - KW'(1));

    always_comb begin
        state_d    = state_q;
        k_len_d    = k_len_q;
        w_len_d    = w_len_q;
        ld_cnt_d   = ld_cnt_q;
        o_d        = o_q;
        k_d        = k_q;
        last_ld_d  = last_ld_q;
        drain_d    = drain_q;
        cfg_err_d  = 1'b0;
        pe_valid_d = pe_valid_q;
        pe_ifmap_d = pe_ifmap_q;
        pe_fltr_d  = pe_fltr_q;
        pe_mult_d  = pe_mult_q;
        pe_acc_d   = pe_acc_q;
        pe_last_d  = pe_last_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        k_len_d  = cfg_fltr_len;
                        w_len_d  = cfg_ifmap_len;
                        ld_cnt_d = '0;
                        state_d  = S_LOAD_FLTR;
                    end
                end
            end
            S_LOAD_FLTR: begin
                if (fltr_valid) begin
                    if (ld_cnt_q == WW'(k_len_q) - WW'(1)) begin
                        ld_cnt_d = '0;
                        state_d  = S_LOAD_IFMAP;
                    end else begin
                        ld_cnt_d = ld_cnt_q + WW'(1);
                    end
                end
            end
            S_LOAD_IFMAP: begin
                if (ifmap_valid) begin
                    if (ld_cnt_q == w_len_q - WW'(1)) begin
                        ld_cnt_d  = '0;
                        o_d       = '0;
                        k_d       = '0;
                        last_ld_d = 1'b0;
                        state_d   = S_COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + WW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                // The output register refills when empty (entry cycle) or when the PE takes the pair.
                if (!pe_valid_q || pe_ready) begin
                    if (last_ld_q) begin
                        pe_valid_d = 1'b0;
                        pe_mult_d  = 1'b0;
                        pe_acc_d   = 1'b0;
                        pe_last_d  = 1'b0;
                        drain_d    = 1'b0;
                        state_d    = S_DRAIN;
                    end else begin
                        pe_valid_d = 1'b1;
                        pe_mult_d  = 1'b1;
                        pe_ifmap_d = pix_mem[o_q + WW'(k_q)];
                        pe_fltr_d  = tap_mem[k_q];
                        pe_acc_d   = (k_q == '0);
                        pe_last_d  = k_is_last;
                        last_ld_d  = k_is_last && (o_q == w_len_q - WW'(k_len_q));
                        if (k_is_last) begin
                            k_d = '0;
                            o_d = o_q + WW'(1);
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            k_len_q    <= '0;
            w_len_q    <= '0;
            ld_cnt_q   <= '0;
            o_q        <= '0;
            k_q        <= '0;
            last_ld_q  <= 1'b0;
            drain_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
            pe_valid_q <= 1'b0;
            pe_ifmap_q <= '0;
            pe_fltr_q  <= '0;
            pe_mult_q  <= 1'b0;
            pe_acc_q   <= 1'b0;
            pe_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_len_q    <= k_len_d;
            w_len_q    <= w_len_d;
            ld_cnt_q   <= ld_cnt_d;
            o_q        <= o_d;
            k_q        <= k_d;
            last_ld_q  <= last_ld_d;
            drain_q    <= drain_d;
            cfg_err_q  <= cfg_err_d;
            pe_valid_q <= pe_valid_d;
            pe_ifmap_q <= pe_ifmap_d;
            pe_fltr_q  <= pe_fltr_d;
            pe_mult_q  <= pe_mult_d;
            pe_acc_q   <= pe_acc_d;
            pe_last_q  <= pe_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fltr_ready && fltr_valid) begin
            tap_mem[ld_cnt_q[KW-1:0]] <= fltr_data;
        end
        if (ifmap_ready && ifmap_valid) begin
            pix_mem[ld_cnt_q] <= ifmap_data;
        end
    end

    assign pe_valid      = pe_valid_q;
    assign pe_ifmap_data = pe_ifmap_q;
    assign pe_fltr_data  = pe_fltr_q;
    assign pe_mult_seln  = pe_mult_q;
    assign pe_acc_seln   = pe_acc_q;
    assign pe_last       = pe_last_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: directed configs plus random data and PE back-pressure,
// checked against a sliding-window reference built from queues.
module tb_pe_operand_feeder;
    localparam int DW = 16;
    localparam int FM = 5;
    localparam int IM = 32;
    localparam int KW = $clog2(FM + 1);
    localparam int WW = $clog2(IM + 1);

    logic          clk;
    logic          rstn;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [KW-1:0] cfg_fltr_len;
    logic [WW-1:0] cfg_ifmap_len;
    logic          fltr_valid, fltr_ready;
    logic [DW-1:0] fltr_data;
    logic          ifmap_valid, ifmap_ready;
    logic [DW-1:0] ifmap_data;
    logic          pe_ready, pe_valid;
    logic [DW-1:0] pe_ifmap_data, pe_fltr_data;
    logic          pe_mult_seln, pe_acc_seln, pe_last;
    logic          busy, cfg_err;

    typedef struct packed {
        logic [DW-1:0] px;
        logic [DW-1:0] tp;
        logic          acc;
        logic          last;
    } pair_t;

    logic [DW-1:0] tap_m [0:7];
    logic [DW-1:0] pix_m [0:63];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    pe_operand_feeder #(.DATA_WIDTH(DW), .FLTR_MAX(FM), .IFMAP_MAX(IM)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fltr_len(cfg_fltr_len), .cfg_ifmap_len(cfg_ifmap_len),
        .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
        .pe_ready(pe_ready), .pe_valid(pe_valid),
        .pe_ifmap_data(pe_ifmap_data), .pe_fltr_data(pe_fltr_data),
        .pe_mult_seln(pe_mult_seln), .pe_acc_seln(pe_acc_seln), .pe_last(pe_last),
        .busy(busy), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ready_streams"}, 64'({fltr_ready, ifmap_ready}), 64'(0));
        chk({tag, "_pe_ctrl"}, 64'({pe_valid, pe_mult_seln, pe_acc_seln, pe_last, cfg_err}), 64'(0));
        chk({tag, "_pe_data"}, 64'({pe_ifmap_data, pe_fltr_data}), 64'(0));
    endtask

    task automatic do_cfg(input int k, input int w, output bit ok);
        ok = (k != 0) && (w != 0) && (k <= FM) && (w <= IM) && (w >= k);
        @(negedge clk);
        chk("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        cfg_valid     = 1'b1;
        cfg_fltr_len  = k[KW-1:0];
        cfg_ifmap_len = w[WW-1:0];
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_err", 64'(cfg_err), 64'(!ok));
        chk("busy_after_cfg", 64'(busy), 64'(ok));
        chk("fltr_ready_after_cfg", 64'(fltr_ready), 64'(ok));
        chk("cfg_ready_after_cfg", 64'(cfg_ready), 64'(!ok));
        if (!ok) begin
            @(negedge clk);
            chk("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
            chk("cfg_ready_after_err", 64'(cfg_ready), 64'(1));
        end
    endtask

    // Loads n filter taps while waving junk on the ifmap stream.
    task automatic load_fltr(input int n);
        int i = 0;
        int cyc = 0;
        chk("ifmap_ready_during_fltr", 64'(ifmap_ready), 64'(0));
        while (i < n && cyc < 500) begin
            fltr_valid  = ($urandom_range(3) != 0);
            fltr_data   = tap_m[i];
            ifmap_valid = 1'b1;
            ifmap_data  = 16'($urandom);
            if (fltr_valid && fltr_ready) i++;
            @(negedge clk);
            cyc++;
        end
        fltr_valid  = 1'b0;
        ifmap_valid = 1'b0;
        chk("fltr_beats", 64'(i), 64'(n));
        chk("streams_after_fltr", 64'({fltr_ready, ifmap_ready}), 64'(2'b01));
    endtask

    // Delivers n of the w ifmap pixels while waving junk on the filter stream.
    task automatic load_ifmap(input int n, input int w);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
            ifmap_valid = ($urandom_range(3) != 0);
            ifmap_data  = pix_m[i];
            fltr_valid  = 1'b1;
            fltr_data   = 16'($urandom);
            if (ifmap_valid && ifmap_ready) i++;
            @(negedge clk);
            cyc++;
        end
        ifmap_valid = 1'b0;
        fltr_valid  = 1'b0;
        chk("ifmap_beats", 64'(i), 64'(n));
        if (n == w) begin
            chk("pe_valid_not_yet", 64'(pe_valid), 64'(0));
            chk("streams_in_compute", 64'({busy, fltr_ready, ifmap_ready}), 64'(3'b100));
        end
    endtask

    task automatic run_compute(input int k, input int w, input bit rnd);
        pair_t q[$];
        pair_t cur, snap, e;
        int total, got, cyc, idx;
        bit hold, first;
        for (int o = 0; o <= w - k; o++)
            for (int j = 0; j < k; j++)
                q.push_back({pix_m[o + j], tap_m[j], (j == 0), (j == k - 1)});
        total = q.size();
        got = 0; cyc = 0; idx = 0; hold = 0; first = 1;
        snap = '0;
        while (q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cur = {pe_ifmap_data, pe_fltr_data, pe_acc_seln, pe_last};
            if (first) chk("first_pe_valid", 64'(pe_valid), 64'(1));
            first = 0;
            if (hold) chk($sformatf("hold_pair%0d", idx), 64'({pe_valid, cur}), 64'({1'b1, snap}));
            if (!rnd) chk("back_to_back", 64'(pe_valid), 64'(1));
            pe_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            hold = 0;
            if (pe_valid) begin
                if (pe_ready) begin
                    e = q.pop_front();
                    chk($sformatf("pair%0d_K%0d_W%0d", idx, k, w),
                        64'({cur, pe_mult_seln}), 64'({e, 1'b1}));
                    got++;
                    idx++;
                end else begin
                    hold = 1;
                    snap = cur;
                end
            end
        end
        pe_ready = 1'b1;
        chk("pair_count", 64'(got), 64'(total));
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_pe_off", d), 64'({pe_valid, pe_mult_seln}), 64'(0));
            chk($sformatf("drain%0d_busy", d), 64'(busy), 64'(1));
        end
        @(negedge clk);
        chk("idle_after_drain", 64'({busy, cfg_ready}), 64'(2'b01));
    endtask

    task automatic scenario(input int k, input int w, input bit rnd);
        bit ok;
        do_cfg(k, w, ok);
        if (ok) begin
            load_fltr(k);
            load_ifmap(w, w);
            run_compute(k, w, rnd);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) tap_m[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) pix_m[i] = 16'($urandom);
    endtask

    initial begin
        int k, w;
        bit ok;
        rstn = 1'b0; cfg_valid = 1'b0; cfg_fltr_len = '0; cfg_ifmap_len = '0;
        fltr_valid = 1'b0; fltr_data = '0; ifmap_valid = 1'b0; ifmap_data = '0;
        pe_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // K=3, W=5, taps 1..3, pixels 1..5: full rate, then with random back-pressure
        for (int i = 0; i < 8; i++) tap_m[i] = 16'(i + 1);
        for (int i = 0; i < 64; i++) pix_m[i] = 16'(i + 1);
        scenario(3, 5, 0);
        scenario(3, 5, 1);

        // rejected configurations
        scenario(4, 3, 0);
        scenario(0, 5, 0);
        scenario(3, 0, 0);
        scenario(6, 10, 0);
        scenario(2, 33, 0);

        // largest legal row
        fill_random();
        scenario(FM, IM, 0);

        // single-tap filter
        tap_m[0] = 16'd7;
        for (int i = 0; i < 4; i++) pix_m[i] = 16'(10 + i);
        scenario(1, 4, 0);

        // K==W
        fill_random();
        scenario(4, 4, 1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            k = int'($urandom_range(1, FM));
            w = int'($urandom_range(k, IM));
            scenario(k, w, 1);
        end

        // reset in the middle of the ifmap load
        fill_random();
        do_cfg(3, 6, ok);
        load_fltr(3);
        load_ifmap(2, 6);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("midload_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_midload_reset");
        fill_random();
        scenario(2, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
